// File: rtl/wishbone_pkg.sv
// Shared widths, FSM state encoding and request bundle for the Wishbone master.
package wishbone_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_master_state_t;

  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wishbone_watchdog.sv
// Saturating cycle counter that flags an access which has been outstanding
// for LIMIT cycles. It holds at LIMIT rather than wrapping, so a stuck access
// stays expired until the next clear.
module wishbone_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] MAX = CW'(LIMIT);

  logic [CW-1:0] count;

  // Clear has priority; count only while enabled and not yet saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == MAX);

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined-mode master. Turns a valid/ready
// request into one cyc/stb transaction and returns a one-cycle response
// pulse. A watchdog aborts accesses that are never acknowledged.
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                sysClk,
  input  logic                sysRst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WB_SEL_W-1:0] req_sel,
  input  logic [WB_ADR_W-1:0] req_adr,
  input  logic [WB_DAT_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [WB_DAT_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                wb_cyc_m,
  output logic                wb_stb_m,
  output logic                wb_we_m,
  output logic [WB_SEL_W-1:0] wb_sel_m,
  output logic [WB_ADR_W-1:0] wb_adr_m,
  output logic [WB_DAT_W-1:0] wb_dat_o_m,
  input  logic [WB_DAT_W-1:0] wb_dat_i_m,
  input  logic                wb_ack_m,
  input  logic                wb_err_m,
  input  logic                wb_stall_m
);

  wb_master_state_t state;
  wb_req_t          req_in;
  logic             accept;
  logic             in_flight;
  logic             bus_taken;
  logic             bus_done;
  logic             bus_tmo;
  logic             expired;

  assign req_in = '{we: req_we, sel: req_sel, adr: req_adr, wdata: req_wdata};

  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign in_flight = (state == REQ) || (state == WAIT);
  // A response only counts once the slave has taken the strobe (not stalled)
  // or while waiting; ack/err during a stall belongs to nothing of ours.
  assign bus_taken = ((state == REQ) && !wb_stall_m) || (state == WAIT);
  assign bus_done  = bus_taken && (wb_ack_m || wb_err_m);
  // A real completion arriving on the expiry cycle beats the timeout.
  assign bus_tmo   = in_flight && expired && !bus_done;

  wishbone_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (sysClk),
    .rst_n   (sysRst),
    .clear   (accept),
    .enable  (in_flight),
    .expired (expired)
  );

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge sysClk or negedge sysRst) begin
    if (!sysRst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wb_cyc_m    <= 1'b0;
      wb_stb_m    <= 1'b0;
      wb_we_m     <= 1'b0;
      wb_sel_m    <= '0;
      wb_adr_m    <= '0;
      wb_dat_o_m  <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            wb_we_m    <= req_in.we;
            wb_sel_m   <= req_in.sel;
            wb_adr_m   <= req_in.adr;
            wb_dat_o_m <= req_in.wdata;
            wb_cyc_m   <= 1'b1;
            wb_stb_m   <= 1'b1;
            req_ready  <= 1'b0;
            state      <= REQ;
          end else begin
            req_ready <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (bus_done || bus_tmo) begin
            wb_cyc_m    <= 1'b0;
            wb_stb_m    <= 1'b0;
            wb_we_m     <= 1'b0;
            wb_sel_m    <= '0;
            rsp_valid   <= 1'b1;
            rsp_err     <= bus_tmo || wb_err_m;
            rsp_timeout <= bus_tmo;
            // Read data is only meaningful for a clean read ack.
            rsp_rdata   <= (bus_done && !wb_err_m && !wb_we_m) ? wb_dat_i_m : '0;
            state       <= RESP;
          end else if (state == REQ && !wb_stall_m) begin
            wb_stb_m <= 1'b0;
            state    <= WAIT;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master. Each task drives one scenario and
// checks cycle-by-cycle against hand-derived values. Inputs are changed and
// outputs sampled 1ns after the rising edge.
module tb_wishbone_master;

  logic        sysClk;
  logic        sysRst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        wb_cyc_m;
  logic        wb_stb_m;
  logic        wb_we_m;
  logic [3:0]  wb_sel_m;
  logic [31:0] wb_adr_m;
  logic [31:0] wb_dat_o_m;
  logic [31:0] wb_dat_i_m;
  logic        wb_ack_m;
  logic        wb_err_m;
  logic        wb_stall_m;

  int n_checks = 0;
  int n_fail   = 0;

  wishbone_master #(.TIMEOUT_CYCLES(8)) dut (
    .sysClk      (sysClk),
    .sysRst      (sysRst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_sel     (req_sel),
    .req_adr     (req_adr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .wb_cyc_m    (wb_cyc_m),
    .wb_stb_m    (wb_stb_m),
    .wb_we_m     (wb_we_m),
    .wb_sel_m    (wb_sel_m),
    .wb_adr_m    (wb_adr_m),
    .wb_dat_o_m  (wb_dat_o_m),
    .wb_dat_i_m  (wb_dat_i_m),
    .wb_ack_m    (wb_ack_m),
    .wb_err_m    (wb_err_m),
    .wb_stall_m  (wb_stall_m)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Present a request in the current (IDLE, ready) cycle and let it be taken.
  task automatic issue(input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_sel   = sel;
    req_adr   = adr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    sysRst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_sel = 4'h0; req_adr = '0; req_wdata = '0;
    wb_dat_i_m = '0; wb_ack_m = 1'b0; wb_err_m = 1'b0; wb_stall_m = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, wb_cyc_m, wb_stb_m, wb_we_m} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {req_ready, rsp_valid, wb_cyc_m, wb_stb_m, wb_we_m});
    end
    n_checks++;
    if ({wb_sel_m, wb_adr_m, wb_dat_o_m, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: sel=%h adr=%h dat=%h rdata=%h err=%b tmo=%b want all 0",
               wb_sel_m, wb_adr_m, wb_dat_o_m, rsp_rdata, rsp_err, rsp_timeout);
    end
    sysRst = 1'b1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b want 0", req_ready);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    // cycle 1: strobe out
    n_checks++;
    if ({wb_cyc_m, wb_stb_m, wb_we_m, req_ready} !== 4'b1100 || wb_adr_m !== 32'h10
        || wb_sel_m !== 4'hF) begin
      n_fail++;
      $display("FAIL read_req: cyc/stb/we/rdy=%b adr=%h sel=%h want 1100 10 f",
               {wb_cyc_m, wb_stb_m, wb_we_m, req_ready}, wb_adr_m, wb_sel_m);
    end
    tick();
    // cycle 2: WAIT, slave acks
    n_checks++;
    if ({wb_cyc_m, wb_stb_m} !== 2'b10) begin
      n_fail++;
      $display("FAIL read_wait: cyc/stb=%b want 10", {wb_cyc_m, wb_stb_m});
    end
    wb_ack_m = 1'b1; wb_dat_i_m = 32'hDEAD_BEEF;
    tick();
    wb_ack_m = 1'b0; wb_dat_i_m = 32'h0;
    // cycle 3: response
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0
        || rsp_timeout !== 1'b0 || wb_cyc_m !== 1'b0) begin
      n_fail++;
      $display("FAIL read_rsp: vld=%b rdata=%h err=%b tmo=%b cyc=%b want 1 deadbeef 0 0 0",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout, wb_cyc_m);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_idle: vld=%b rdy=%b rdata=%h want 0 1 deadbeef",
               rsp_valid, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_write_stall();
    wb_stall_m = 1'b1;
    issue(1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if ({wb_cyc_m, wb_stb_m, wb_we_m} !== 3'b111 || wb_sel_m !== 4'b0011
          || wb_adr_m !== 32'h20 || wb_dat_o_m !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL wr_stall_c%0d: cyc/stb/we=%b sel=%b adr=%h dat=%h want 111 0011 20 12345678",
                 i, {wb_cyc_m, wb_stb_m, wb_we_m}, wb_sel_m, wb_adr_m, wb_dat_o_m);
      end
      if (i == 4) wb_stall_m = 1'b0;
      tick();
    end
    n_checks++;
    if ({wb_cyc_m, wb_stb_m} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_wait: cyc/stb=%b want 10", {wb_cyc_m, wb_stb_m});
    end
    wb_ack_m = 1'b1; wb_dat_i_m = 32'hAAAA_5555;
    tick();
    wb_ack_m = 1'b0; wb_dat_i_m = 32'h0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0
        || wb_we_m !== 1'b0 || wb_sel_m !== 4'h0 || wb_adr_m !== 32'h20) begin
      n_fail++;
      $display("FAIL wr_rsp: vld=%b rdata=%h err=%b we=%b sel=%h adr=%h want 1 0 0 0 0 20",
               rsp_valid, rsp_rdata, rsp_err, wb_we_m, wb_sel_m, wb_adr_m);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    issue(1'b0, 4'hF, 32'h0000_0030, 32'h0);
    wb_ack_m = 1'b1; wb_dat_i_m = 32'hCAFE_F00D;
    tick();
    wb_ack_m = 1'b0; wb_dat_i_m = 32'h0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || wb_cyc_m !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_rsp: vld=%b rdata=%h cyc=%b want 1 cafef00d 0",
               rsp_valid, rsp_rdata, wb_cyc_m);
    end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_idle: rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
    // back-to-back: next request accepted in this same cycle
    issue(1'b0, 4'hF, 32'h0000_0034, 32'h0);
    n_checks++;
    if (wb_stb_m !== 1'b1 || wb_adr_m !== 32'h34) begin
      n_fail++;
      $display("FAIL b2b_req: stb=%b adr=%h want 1 34", wb_stb_m, wb_adr_m);
    end
    wb_ack_m = 1'b1; wb_dat_i_m = 32'h0000_1111;
    tick();
    wb_ack_m = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_1111) begin
      n_fail++;
      $display("FAIL b2b_rsp: vld=%b rdata=%h want 1 00001111", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_err_ack();
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    tick();
    wb_ack_m = 1'b1; wb_err_m = 1'b1; wb_dat_i_m = 32'h5555_5555;
    tick();
    wb_ack_m = 1'b0; wb_err_m = 1'b0; wb_dat_i_m = 32'h0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0
        || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL err_rsp: vld=%b err=%b tmo=%b rdata=%h want 1 1 0 0",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    issue(1'b0, 4'hF, 32'hF000_0000, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      n_checks++;
      if (wb_cyc_m !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_c%0d: cyc=%b vld=%b want 1 0", i, wb_cyc_m, rsp_valid);
      end
      tick();
    end
    n_checks++;
    if (wb_cyc_m !== 1'b0 || wb_stb_m !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1
        || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_rsp: cyc=%b stb=%b vld=%b err=%b tmo=%b rdata=%h want 0 0 1 1 1 0",
               wb_cyc_m, wb_stb_m, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    // late acks in RESP and IDLE must not produce anything
    wb_ack_m = 1'b1; wb_dat_i_m = 32'h7777_7777;
    tick();
    tick();
    wb_ack_m = 1'b0; wb_dat_i_m = 32'h0;
    n_checks++;
    if (rsp_valid !== 1'b0 || wb_cyc_m !== 1'b0 || req_ready !== 1'b1
        || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_late_ack: vld=%b cyc=%b rdy=%b tmo=%b rdata=%h want 0 0 1 1 0",
               rsp_valid, wb_cyc_m, req_ready, rsp_timeout, rsp_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    issue(1'b0, 4'hF, 32'h0000_0050, 32'h0);
    tick();
    n_checks++;
    if ({wb_cyc_m, wb_stb_m} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstw_wait: cyc/stb=%b want 10", {wb_cyc_m, wb_stb_m});
    end
    #2;
    sysRst = 1'b0;
    #1;
    n_checks++;
    if ({wb_cyc_m, wb_stb_m, rsp_valid, req_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstw_async: cyc/stb/vld/rdy=%b want 0000",
               {wb_cyc_m, wb_stb_m, rsp_valid, req_ready});
    end
    tick();
    sysRst = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || wb_cyc_m !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_ready: rdy=%b cyc=%b want 1 0", req_ready, wb_cyc_m);
    end
    issue(1'b0, 4'hF, 32'h0000_0060, 32'h0);
    tick();
    wb_ack_m = 1'b1; wb_dat_i_m = 32'h0BAD_F00D;
    tick();
    wb_ack_m = 1'b0; wb_dat_i_m = 32'h0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0
        || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_read: vld=%b rdata=%h err=%b tmo=%b want 1 0badf00d 0 0",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_zero_wait();
    test_err_ack();
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
